// File: rtl/systolic_pkg.sv
// Shared types, FSM state encoding and sizing helpers for the systolic array sequencer.
package systolic_pkg;

  localparam int SYS_N = 4;

  typedef logic signed [SYS_N-1:0][SYS_N-1:0][7:0]   op_mat_t;
  typedef logic signed [SYS_N-1:0][2*SYS_N-2:0][7:0] stream_t;
  typedef logic signed [SYS_N-1:0][SYS_N-1:0][31:0]  res_mat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_RUN,
    ST_CAPT,
    ST_DONE
  } state_t;

  function automatic int run_len(input int n);
    return 3 * n - 1;
  endfunction

  function automatic int skew_depth(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_buffer.sv
// Parallel-load, zero-fill shift register feeding one array row or column stream.
module skew_buffer #(
  parameter int DEPTH = 7
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    load,
  input  logic                    shift,
  input  logic signed [DEPTH-1:0][7:0] data,
  output logic signed [DEPTH-1:0][7:0] q
);

  logic signed [DEPTH-1:0][7:0] sr_q;
  logic signed [DEPTH-1:0][7:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = data;
    end else if (shift) begin
      // element 0 is what the array consumes; zeros enter at the far end
      sr_d = {8'h00, sr_q[DEPTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the NxN int8 systolic array: operand skew, process enable, result capture.
// Define SYSTOLIC_CTRL_BASELINE_EN to snapshot and subtract the pre-job accumulator values.
//   state | meaning
//   IDLE  | waiting for an operand pair, o_ready high
//   BASE  | snapshot array accumulators (baseline build only)
//   RUN   | stream skewed operands, array process enable high
//   CAPT  | capture the array result
//   DONE  | result valid, waiting for i_ready
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = SYS_N
) (
  input  logic                               i_clk,
  input  logic                               i_arst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic signed [N-1:0][N-1:0][7:0]    i_a,
  input  logic signed [N-1:0][N-1:0][7:0]    i_b,
  output logic                               o_doProcess,
  output logic signed [N-1:0][2*N-2:0][7:0]  o_row,
  output logic signed [N-1:0][2*N-2:0][7:0]  o_col,
  input  logic signed [N-1:0][N-1:0][31:0]   i_c,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic signed [N-1:0][N-1:0][31:0]   o_c,
  output logic                               o_busy
);

  localparam int SKEW    = skew_depth(N);
  localparam int RUN_CYC = run_len(N);
  localparam int CW      = $clog2(RUN_CYC);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic buf_load;
  logic buf_shift;

  logic signed [N-1:0][SKEW-1:0][7:0] row_ld;
  logic signed [N-1:0][SKEW-1:0][7:0] col_ld;

  logic signed [N-1:0][N-1:0][31:0] c_q, c_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_load  = 1'b0;
    buf_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          buf_load = 1'b1;
          cnt_d    = CW'(RUN_CYC - 1);
`ifdef SYSTOLIC_CTRL_BASELINE_EN
          state_d  = ST_BASE;
`else
          state_d  = ST_RUN;
`endif
        end
      end
      ST_BASE: state_d = ST_RUN;
      ST_RUN: begin
        buf_shift = 1'b1;
        // one extra cycle past the product flushes the inter-PE registers
        if (cnt_q == '0) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPT: state_d = ST_DONE;
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    row_ld = '0;
    col_ld = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        row_ld[i][i+k] = i_a[i][k];
        col_ld[i][i+k] = i_b[k][i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_buf
    skew_buffer #(.DEPTH(SKEW)) u_row (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .load  (buf_load),
      .shift (buf_shift),
      .data  (row_ld[g]),
      .q     (o_row[g])
    );
    skew_buffer #(.DEPTH(SKEW)) u_col (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .load  (buf_load),
      .shift (buf_shift),
      .data  (col_ld[g]),
      .q     (o_col[g])
    );
  end

`ifdef SYSTOLIC_CTRL_BASELINE_EN
  logic signed [N-1:0][N-1:0][31:0] base_q, base_d;

  always_comb begin
    base_d = base_q;
    if (state_q == ST_BASE) begin
      base_d = i_c;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  always_comb begin
    c_d = c_q;
    if (state_q == ST_CAPT) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          c_d[i][j] = i_c[i][j] - base_q[i][j];
        end
      end
    end
  end
`else
  always_comb begin
    c_d = c_q;
    if (state_q == ST_CAPT) begin
      c_d = i_c;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign o_c         = c_q;
  assign o_ready     = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_doProcess = (state_q == ST_RUN);
  assign o_valid     = (state_q == ST_DONE);

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the NxN int8 systolic array. It accepts one pair of NxN operand matrices A and B through a valid/ready handshake, loads them into skewed shift buffers, and drives the array's row and column streams and its process enable for exactly the cycles a product needs. It then returns C = A×B through a valid/ready handshake. It sits between the ECG feature/weight buffers and the array, and it is the only block that drives the array's process enable.

## Interface
Parameters:
- N, 4, array dimension. Operands are NxN, skew depth is 2N-1.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_arst  in  1  asynchronous, active-high reset. Shared with the array.
- i_valid  in  1  operand pair on i_a/i_b is valid.
- o_ready  out  1  controller can accept a job. High only in IDLE.
- i_a  in  signed [N-1:0][N-1:0][7:0]  matrix A, [row][col].
- i_b  in  signed [N-1:0][N-1:0][7:0]  matrix B, [row][col].
- o_doProcess  out  1  array process enable.
- o_row  out  signed [N-1:0][2N-2:0][7:0]  skewed A streams to the array row inputs.
- o_col  out  signed [N-1:0][2N-2:0][7:0]  skewed B streams to the array column inputs, [col][k].
- i_c  in  signed [N-1:0][N-1:0][31:0]  array accumulator outputs.
- o_valid  out  1  result on o_c is valid.
- i_ready  in  1  consumer accepts the result.
- o_c  out  signed [N-1:0][N-1:0][31:0]  result matrix.
- o_busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE → BASE on i_valid && o_ready.
  - BASE → RUN after 1 cycle.
  - RUN → CAPT after 3N-1 cycles.
  - CAPT → DONE after 1 cycle.
  - DONE → IDLE on i_ready.
- Load at handshake:
  - rowBuf[i][k] = A[i][k-i] for i ≤ k < i+N, else 0.
  - colBuf[j][k] = B[k-j][j] for j ≤ k < j+N, else 0.
- o_row = rowBuf and o_col = colBuf, driven directly from the registers.
- In each RUN cycle, every buffer shifts: element k takes k+1, and element 2N-2 takes 0.
- o_doProcess = 1 exactly in RUN.
- RUN length is 3N-1 cycles:
  - 3N-2 cycles complete the product.
  - The extra cycle flushes zeros through every inter-PE register, so the next job starts from clean pipelines.
- BASE: base <= i_c. This snapshots the accumulators, which hold because the array is idle.
- CAPT: o_c <= i_c - base, element-wise, modulo 2^32 (wrap, no saturation). This cancels the result of the previous job.
- DONE: o_valid = 1. o_c and o_valid hold while i_ready = 0.
- New operands arriving while busy are not accepted (o_ready = 0). i_a/i_b are sampled only at the handshake.

## Timing
- Reset values:
  - state IDLE
  - o_ready 1
  - o_busy 0
  - o_valid 0
  - o_doProcess 0
  - o_row, o_col, o_c, base all 0
- Handshake edge is t0:
  - BASE in t0+1.
  - RUN in t0+2 … t0+3N.
  - CAPT in t0+3N+1.
  - o_valid rises in t0+3N+2. For N=4, the result is visible 14 cycles after acceptance.
- Result transfer is on the edge where o_valid && i_ready. o_ready is high the next cycle.
  - Minimum job-to-job spacing is 3N+3 cycles.
- Reset mid-job:
  - Everything returns to the reset values immediately.
  - The job is dropped and no o_valid is produced.
  - The array is cleared by the same reset.
- i_ready high already before DONE: DONE lasts exactly 1 cycle.

## Configuration
- SYSTOLIC_CTRL_BASELINE_EN defined:
  - Includes the base register, the BASE state and the subtraction described above.
  - Latency is 3N+2.
- Undefined:
  - No base register and no BASE state; IDLE goes straight to RUN.
  - CAPT stores i_c unmodified, so results accumulate across jobs unless i_arst is pulsed.
  - Latency is 3N+1.

## Structure
- Package systolic_pkg holds:
  - typedefs for the int8 operand matrix, the skewed stream bundle and the int32 result matrix
  - the state enum (IDLE, BASE, RUN, CAPT, DONE)
  - localparam functions for RUN length (3N-1) and skew depth (2N-1)
- Sub-module skew_buffer: one parallel-load, zero-fill shift register of depth 2N-1 with ports load/shift/data. It is instantiated 2N times (N rows, N columns).
- The FSM, cycle counter and baseline/capture logic live in systolic_ctrl.

## Test plan
- N=4, A=identity, B[r][c]=4r+c+1 → o_c equals B (1…16). o_valid rises exactly 14 cycles after the handshake.
- Back-to-back, with the macro defined: job 1 as above, then job 2 with A=all 2 and B=all 3 → job 2 o_c all 24.
- Same sequence with the macro undefined → job 2 o_c[r][c] = 24 + B1[r][c]. Latency is 13.
- A=all -128, B=all -128 → o_c all 65536. A=all 127, B=all -128 → o_c all -65024.
- Hold i_ready low 6 cycles in DONE → o_valid, o_c and o_busy stable, o_ready 0, and a new i_valid is ignored. Raise i_ready → IDLE next cycle.
- Assert i_arst at RUN cycle 5 → all outputs 0 in the same cycle and o_ready=1. The next job (A=identity, B=all 7) returns o_c all 7.
